// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship damage generator.
// Holds the one-hot sequencer state encoding, the station index constants
// and the 16-bit LFSR tap set (x^16+x^14+x^13+x^11+1, left-shifting form).
package nexys_starship_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ARM   = 4'b0010,
    S_COUNT = 4'b0100,
    S_FIRE  = 4'b1000
  } state_e;

  localparam logic [1:0] ST_RIGHT = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_UP    = 2'd2;
  localparam logic [1:0] ST_DOWN  = 2'd3;

  // Bits 15,13,12,10 feed back into bit 0 on each left shift.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR.
// Ports:
//   Clk   - system clock
//   Reset - synchronous active-high reset, loads SEED
//   lfsr  - current LFSR state
// Shifts every cycle; only Reset reloads it.
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;

  always_ff @(posedge Clk) begin
    if (Reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_step(lfsr_q);
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/nexys_starship_damage_gen.sv
// Break-event generator for the Nexys Starship repair stations.
// After a randomised number of game ticks, pulses exactly one unbroken
// station for one cycle and publishes the repair combo it must latch.
// Ports:
//   Clk, Reset      - clock, synchronous active-high reset
//   play_flag       - game running; low pauses the countdown
//   gameover_ctrl   - abort to IDLE, suppresses any pending pulse
//   broken_flags    - {down, up, left, right} broken status
//   station_random  - one-hot, one-cycle break pulse (bit 0 = RR_random)
//   random_hex      - repair combo, updated with each pulse, held otherwise
//   events_fired    - saturating count of pulses since reset
module nexys_starship_damage_gen
  import nexys_starship_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1_000_000,
  parameter int unsigned MIN_GAP   = 8,
  parameter logic [3:0]  GAP_MASK  = 4'hF,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  input  logic [3:0] broken_flags,
  output logic [3:0] station_random,
  output logic [3:0] random_hex,
  output logic [7:0] events_fired
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [15:0]   lfsr;
  logic          lfsr_unused;
  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    gap_q, gap_d;
  logic [3:0]    station_q, station_d;
  logic [3:0]    hex_q, hex_d;
  logic [7:0]    events_q, events_d;
  logic          found;
  logic [1:0]    sel, idx;

  nexys_starship_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .lfsr  (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:10];

  // Start at the random candidate lfsr[9:8], walk upward mod 4, keep the
  // first station that is not broken.
  always_comb begin
    found = 1'b0;
    sel   = lfsr[9:8];
    idx   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = lfsr[9:8] + 2'(k);
      if (!found && !broken_flags[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    gap_d     = gap_q;
    station_d = '0;
    hex_d     = hex_q;
    events_d  = events_q;
    case (state_q)
      S_IDLE: begin
        if (play_flag && !gameover_ctrl) state_d = S_ARM;
      end
      S_ARM: begin
        gap_d   = 5'(MIN_GAP) + {1'b0, lfsr[3:0] & GAP_MASK};
        presc_d = '0;
        state_d = S_COUNT;
      end
      S_COUNT: begin
        if (play_flag) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            gap_d   = gap_q - 5'd1;
            if (gap_q == 5'd1) state_d = S_FIRE;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      S_FIRE: begin
        if (found) begin
          station_d = 4'b0001 << sel;
          hex_d     = (lfsr[7:4] == 4'h0) ? 4'hF : lfsr[7:4];
          if (events_q != 8'hFF) events_d = events_q + 8'd1;
        end
        state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a FIRE in progress.
    if (gameover_ctrl && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      station_d = '0;
      hex_d     = hex_q;
      events_d  = events_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      gap_q     <= '0;
      station_q <= '0;
      hex_q     <= '0;
      events_q  <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      gap_q     <= gap_d;
      station_q <= station_d;
      hex_q     <= hex_d;
      events_q  <= events_d;
    end
  end

  assign station_random = station_q;
  assign random_hex     = hex_q;
  assign events_fired   = events_q;

endmodule

// File: doc/nexys_starship_damage_gen.md
# nexys_starship_damage_gen

Upstream event source for the Nexys Starship station repair FSMs. It runs a free-running 16-bit LFSR and a tick-prescaled countdown. When the countdown expires, it issues a one-cycle "break" pulse to exactly one currently-unbroken station, together with the 4-bit repair combo that station must latch. Bit 0 of its pulse vector is the `RR_random` input of the right-side repair FSM; `random_hex` feeds every repair FSM's `random_hex` input.

## Interface
- `TICK_DIV`, default 1_000_000: clock cycles per game tick (≥2).
- `MIN_GAP`, default 8: minimum ticks between break events (≥1).
- `GAP_MASK`, default 4'hF: mask on LFSR bits added to `MIN_GAP`.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value (nonzero).
- `Clk` in 1: system clock; one clock domain.
- `Reset` in 1: synchronous, active-high reset.
- `play_flag` in 1: game running; low pauses the countdown.
- `gameover_ctrl` in 1: abort to IDLE.
- `broken_flags` in 4: current broken status {down, up, left, right}; bit 0 is `right_broken`.
- `station_random` out 4: one-hot, one-cycle break pulse; bit 0 drives `RR_random`.
- `random_hex` out 4: repair combo; valid in the pulse cycle, held until the next pulse.
- `events_fired` out 8: saturating count of pulses issued since reset.

## Operation
- Reset values: state IDLE, `station_random`=0, `random_hex`=0, `events_fired`=0, LFSR=`LFSR_SEED`, prescaler=0, gap timer=0.
- LFSR:
  - Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every cycle in every state, including IDLE, so player timing adds entropy.
  - Never reloaded except by `Reset`.
- States:
  - IDLE: outputs quiet. If `play_flag` && !`gameover_ctrl`, go to ARM.
  - ARM (1 cycle): gap timer ← `MIN_GAP` + (lfsr[3:0] & `GAP_MASK`), at 5-bit width with no overflow; prescaler ← 0; go to COUNT.
  - COUNT:
    - While `play_flag`=1, the prescaler counts 0..`TICK_DIV`-1 and wraps.
    - On wrap, the gap timer decrements. On a wrap with timer==1, go to FIRE.
    - While `play_flag`=0, prescaler and timer hold.
  - FIRE (1 cycle):
    - Candidate index = lfsr[9:8]. If that station is broken, scan upward modulo 4 and take the first unbroken one.
    - If an unbroken station is found: assert its `station_random` bit; `random_hex` ← lfsr[7:4], with 4'h0 substituted by 4'hF; `events_fired` increments, saturating at 255.
    - If all four stations are broken: no pulse, `random_hex` holds, count holds.
    - Always go to ARM.
- `gameover_ctrl`=1 in any non-IDLE state: next state IDLE, `station_random` forced to 0 that edge. It takes priority over FIRE. `events_fired` is unaffected.
- `Reset` mid-operation discards any pending event; no pulse is issued on the following edge.

## Timing
- All outputs are registered.
- `station_random` is high for exactly one cycle: the cycle after the FIRE state is entered. `random_hex` changes on the same edge.
- Event spacing is at least `MIN_GAP`·`TICK_DIV` + 2 cycles. Stale `broken_flags` (1-cycle repair-FSM lag) therefore cannot cause a double-fire on the same station.
- First event after `play_flag` rises: 2 + gap·`TICK_DIV` cycles, where gap ∈ [`MIN_GAP`, `MIN_GAP`+15].
- Simultaneous `play_flag`=0 and a tick wrap: no decrement.

## Structure
- Shared package `nexys_starship_pkg` holds:
  - State localparams (one-hot, 4 bits).
  - Station index constants: ST_RIGHT=0, ST_LEFT=1, ST_UP=2, ST_DOWN=3.
  - LFSR tap constants.
- Sub-module `nexys_starship_lfsr16`: ports `Clk`, `Reset`, parameter SEED, output `lfsr[15:0]`. The sequencer FSM, prescaler and station selector stay in the top module.

## Test plan
- Reset, then `play_flag`=1, `TICK_DIV`=4, `MIN_GAP`=2, `GAP_MASK`=0 -> exactly one `station_random` pulse 10 cycles after `play_flag` rises; `random_hex` nonzero; `events_fired`=1.
- `broken_flags`=4'b0111 with the LFSR forced so candidate=0 -> pulse on bit 3 only.
- `broken_flags`=4'hF at FIRE -> no pulse; `random_hex` and `events_fired` unchanged; re-ARM observed.
- `play_flag` dropped for 20 cycles mid-COUNT -> first pulse delayed by exactly 20 cycles.
- `gameover_ctrl` asserted on the FIRE cycle -> no pulse; IDLE next cycle; a new `play_flag` restarts from ARM.
- 300 events with `TICK_DIV`=2, `MIN_GAP`=1 -> `events_fired` saturates at 255; each pulse is one-hot and exactly one cycle wide.
